mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single line-wide lower memory/AXI port between the instruction-cache controller (I side) and the data-cache controller (D side).
- Grants one requester, holds one transaction (refill read or writeback write) outstanding at a time, and routes the response back to that requester.
- Sits between both cache controllers and the memory interface. Each controller sees a private memory port with a level request and an acknowledge.

Parameters:
- LINE_SIZE, 64, cache line size in bytes; data buses are LINE_SIZE*8 bits.
- ADDR_WIDTH, 32, memory address width.
- FIXED_PRIORITY, 0: 0 = round-robin on conflict; 1 = D side always wins a conflict.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-side request; level, held until i_ack
- i_we  in  1  I-side 1=write, 0=read
- i_addr  in  ADDR_WIDTH  I-side line address
- i_wdata  in  LINE_SIZE*8  I-side write line
- i_cancel  in  1  I-side flush; discards its outstanding response
- i_ack  out  1  I-side request accepted by memory
- i_resp_valid  out  1  I-side response pulse
- i_resp_data  out  LINE_SIZE*8  I-side read line
- d_req, d_we, d_addr, d_wdata  in  (same widths)  D-side equivalents
- d_ack, d_resp_valid, d_resp_data  out  (same widths)  D-side equivalents
- mem_req  out  1  downstream request pulse
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_write_data  out  LINE_SIZE*8  downstream write line
- mem_ready  in  1  downstream can accept a request
- mem_data_valid  in  1  downstream transaction complete
- mem_read_data  in  LINE_SIZE*8  downstream read line

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, last_grant = I (so D wins the first conflict under round-robin), cancel flag 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - On any req, select a winner and latch its we/addr/wdata and the owner id; go to ISSUE next cycle.
  - Conflict: FIXED_PRIORITY=1 picks D. Otherwise pick the side not equal to last_grant.
- ISSUE:
  - mem_req = mem_ready (combinational). mem_we/mem_addr/mem_write_data come from the latch and are stable throughout ISSUE and WAIT.
  - In the cycle mem_ready=1: pulse the owner's ack (combinational, same cycle as mem_req), set last_grant = owner, go to WAIT.
  - mem_ready=0: stay in ISSUE with mem_req=0.
- WAIT:
  - On mem_data_valid, register mem_read_data into the owner's resp_data and pulse the owner's resp_valid one cycle later. Return to IDLE.
  - resp_valid is pulsed for writes as well; resp_data is then don't-care but holds its last value.
- Latency: req in cycle N (IDLE) → earliest mem_req/ack in N+1. mem_data_valid in cycle M → resp_valid in M+1. Earliest next grant is IDLE at M+1, so the next mem_req is at M+2.
- Requesters drop req the cycle after ack; a req still high after ack is treated as a new request.
- The loser's req is held and served next. No starvation under round-robin: it is granted at the very next conflict.
- i_cancel while the I side owns ISSUE: the transaction is abandoned with no mem_req; return to IDLE.
- i_cancel while the I side owns WAIT:
  - Set the cancel flag; the memory transaction still completes.
  - i_resp_valid is suppressed.
  - The flag is cleared on return to IDLE.
- i_cancel when the I side is not the owner: ignored.
- mem_data_valid in IDLE or ISSUE: ignored.
- rst asserted mid-transaction: immediate return to reset values. Downstream cleanup is the system's responsibility.
- resp_data registers are not cleared except by reset.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds 32-bit saturating counters, each exposed as a 32-bit output and zeroed on rst:
  - perf_i_grants, perf_d_grants: incremented on each ack.
  - perf_conflict_cycles: cycles where both reqs are high and at least one waits.
  - perf_stray_valid: mem_data_valid seen outside WAIT.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE/ISSUE/WAIT
  - owner encoding OWNER_I=0, OWNER_D=1
  - LINE_BITS = LINE_SIZE*8 helper constant
- One natural sub-module: mem_arb_rr_pick. It is a combinational 2-way picker taking i_req, d_req, last_grant and FIXED_PRIORITY, and returning grant_valid and grant_id.

Test Plan:
- Single I read:
  - i_req, i_addr=0x0000_1040, mem_ready=1.
  - Expect: mem_req/i_ack 1 cycle later with mem_addr=0x1040, mem_we=0.
  - mem_data_valid with data 0xA5.. → i_resp_valid and i_resp_data=0xA5.. the next cycle; d_resp_valid stays 0.
- Simultaneous I and D requests after reset, FIXED_PRIORITY=0:
  - D granted first. I is granted next, after D's response.
  - Repeat both: the order alternates D, I, D, I.
- FIXED_PRIORITY=1 with both requests held continuously: D is granted every time, I never granted.
- D writeback:
  - d_we=1, d_wdata=all 0x5A, mem_ready=0 for 3 cycles.
  - Expect: mem_req=0 for those 3 cycles with mem_addr/mem_write_data stable; then mem_req with d_ack; d_resp_valid after mem_data_valid.
- i_cancel cases:
  - During I-owned WAIT: mem_data_valid arrives, no i_resp_valid; a pending d_req is granted at the next IDLE.
  - During I-owned ISSUE with mem_ready=0: no mem_req ever issued.
- Reset:
  - rst during WAIT: all outputs 0 next cycle.
  - Stray mem_data_valid afterwards produces no resp_valid; perf_stray_valid=1 when MEM_ARB_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT)
//   owner_e     : requester identity (OWNER_I = I-cache, OWNER_D = D-cache)
//   LINE_BITS   : line width in bits for the default 64-byte line
//   line_bits() : line width in bits for an arbitrary line size
//   sat_inc32() : saturating 32-bit increment (performance counters)
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} arb_state_e;
  typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_e;

  localparam int LINE_SIZE_DEF = 64;
  localparam int LINE_BITS     = LINE_SIZE_DEF * 8;

  function automatic int line_bits(input int line_size);
    return line_size * 8;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way picker between the I and D requesters.
//   i_req, d_req : pending requests
//   last_grant   : side that most recently won memory
//   grant_valid  : at least one request pending
//   grant_id     : chosen side
// On a conflict, FIXED_PRIORITY != 0 always picks D; otherwise the side that
// did not win last time is picked.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_id
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = OWNER_I;
    if (d_req && !i_req)
      grant_id = OWNER_D;
    else if (d_req && i_req)
      grant_id = (FIXED_PRIORITY != 0 || last_grant == OWNER_I) ? OWNER_D : OWNER_I;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache controllers.
// One transaction (refill read or writeback write) is outstanding at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   i_* / d_* request side   : req (level, held until ack), we, addr, wdata
//   i_cancel                 : I-side flush; abandons/suppresses the I transaction
//   i_ack / d_ack            : request accepted by memory (same cycle as mem_req)
//   *_resp_valid/_resp_data  : one-cycle response pulse and registered read line
//   mem_*                    : downstream request/response port
// Optional: define MEM_ARB_PERF_CNT_EN to add 32-bit saturating counters
//   perf_i_grants, perf_d_grants, perf_conflict_cycles, perf_stray_valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [LINE_SIZE*8-1:0]    i_wdata,
  input  logic                      i_cancel,
  output logic                      i_ack,
  output logic                      i_resp_valid,
  output logic [LINE_SIZE*8-1:0]    i_resp_data,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [LINE_SIZE*8-1:0]    d_wdata,
  output logic                      d_ack,
  output logic                      d_resp_valid,
  output logic [LINE_SIZE*8-1:0]    d_resp_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [LINE_SIZE*8-1:0]    mem_write_data,
  input  logic                      mem_ready,
  input  logic                      mem_data_valid,
  input  logic [LINE_SIZE*8-1:0]    mem_read_data
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]               perf_i_grants,
  output logic [31:0]               perf_d_grants,
  output logic [31:0]               perf_conflict_cycles,
  output logic [31:0]               perf_stray_valid
`endif
);
  localparam int LB = line_bits(LINE_SIZE);

  arb_state_e state_q, state_d;
  owner_e     owner_q, last_grant_q, grant_id;
  logic       grant_valid, cancel_q;
  logic       i_own, issue_kill, issue_go;

  logic                  lat_we_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [LB-1:0]         lat_wdata_q;

  mem_arb_rr_pick #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign i_own      = (owner_q == OWNER_I);
  // A flush while the I side still waits for mem_ready drops the request
  // before it is ever presented downstream.
  assign issue_kill = (state_q == ISSUE) && i_own && i_cancel;
  assign issue_go   = (state_q == ISSUE) && mem_ready && !issue_kill;

  // Downstream request fields come straight from the latch so they stay
  // stable across ISSUE and WAIT.
  assign mem_we         = lat_we_q;
  assign mem_addr       = lat_addr_q;
  assign mem_write_data = lat_wdata_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   if (issue_kill) state_d = IDLE;
               else if (mem_ready) state_d = WAIT;
      WAIT:    if (mem_data_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    mem_req = issue_go;
    i_ack   = issue_go && i_own;
    d_ack   = issue_go && !i_own;
  end

  // request latch, ownership, cancel flag and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_I;
      cancel_q     <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      unique case (state_q)
        IDLE: if (grant_valid) begin
          owner_q  <= grant_id;
          cancel_q <= 1'b0;
          if (grant_id == OWNER_D) begin
            lat_we_q    <= d_we;
            lat_addr_q  <= d_addr;
            lat_wdata_q <= d_wdata;
          end else begin
            lat_we_q    <= i_we;
            lat_addr_q  <= i_addr;
            lat_wdata_q <= i_wdata;
          end
        end
        ISSUE: if (issue_go) last_grant_q <= owner_q;
        WAIT: begin
          if (i_own && i_cancel) cancel_q <= 1'b1;
          if (mem_data_valid) begin
            cancel_q <= 1'b0;
            // A flush arriving in the completion cycle also suppresses the pulse.
            if (i_own) begin
              i_resp_data  <= mem_read_data;
              i_resp_valid <= !(cancel_q || i_cancel);
            end else begin
              d_resp_data  <= mem_read_data;
              d_resp_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants        <= '0;
      perf_d_grants        <= '0;
      perf_conflict_cycles <= '0;
      perf_stray_valid     <= '0;
    end else begin
      if (i_ack) perf_i_grants <= sat_inc32(perf_i_grants);
      if (d_ack) perf_d_grants <= sat_inc32(perf_d_grants);
      // Only one side can be acked per cycle, so both high means one waits.
      if (i_req && d_req) perf_conflict_cycles <= sat_inc32(perf_conflict_cycles);
      if (mem_data_valid && state_q != WAIT) perf_stray_valid <= sat_inc32(perf_stray_valid);
    end
  end
`endif
endmodule
